// File: rtl/aurora_cdc_sync_pkg.sv
// Shared definitions for the Aurora clock-domain-crossing synchroniser.
// Contents:
//   CDC_PULSE / CDC_LEVEL / CDC_LEVEL_ACK  - values for the c_cdc_type parameter
//   MTBF_MIN / MTBF_MAX                    - legal synchroniser depth range
//   clamp_mtbf()                           - keeps a requested depth inside that range
package aurora_cdc_sync_pkg;

    localparam int unsigned CDC_PULSE     = 0;
    localparam int unsigned CDC_LEVEL     = 1;
    localparam int unsigned CDC_LEVEL_ACK = 2;

    localparam int unsigned MTBF_MIN = 2;
    localparam int unsigned MTBF_MAX = 6;

    // Out-of-range depths are clamped so a bad override never yields a 0/1-flop chain.
    function automatic int unsigned clamp_mtbf(input int unsigned stages);
        if (stages < MTBF_MIN) begin
            return MTBF_MIN;
        end
        if (stages > MTBF_MAX) begin
            return MTBF_MAX;
        end
        return stages;
    endfunction

endpackage

// File: rtl/aurora_cdc_sync_chain.sv
// Multi-flop synchroniser chain with asynchronous active-low clear.
// Each of the WIDTH bits is synchronised independently through STAGES flops.
// Ports:
//   clk    in   destination-domain clock
//   rst_n  in   async active-low clear of every chain flop
//   d      in   WIDTH-bit asynchronous input
//   q      out  WIDTH-bit synchronised output (last chain stage)
module aurora_cdc_sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Metastability chain: kept together by placement and never packed into SRLs.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [STAGES-1:0][WIDTH-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/aurora_cdc_sync.sv
// Parameterised clock-domain-crossing synchroniser (prmry_aclk -> scndry_aclk).
// Modes (c_cdc_type):
//   0 pulse     : toggle handshake, one scndry pulse per prmry pulse, prmry_ack pulse on return
//   1 level     : plain multi-flop level synchroniser
//   2 level+ack : level synchroniser, synchronised level returned as prmry_ack
// In the Aurora reset logic scndry_aclk is USER_CLK and scndry_out drives gt_rst_sync.
// Ports:
//   prmry_aclk       in   source clock
//   prmry_rst_n      in   source async active-low reset (only when c_reset_state=1)
//   scndry_aclk      in   destination clock
//   scndry_rst_n     in   destination async active-low reset (only when c_reset_state=1)
//   prmry_in         in   single-bit source input
//   prmry_vect_in    in   vector source input, c_vector_width bits
//   prmry_ack        out  source-domain acknowledge (modes 0 and 2), else 0
//   scndry_out       out  synchronised single bit (0 when c_single_bit=0)
//   scndry_vect_out  out  synchronised vector (0 when c_single_bit=1)
module aurora_cdc_sync
    import aurora_cdc_sync_pkg::*;
#(
    parameter int unsigned c_cdc_type     = CDC_LEVEL,
    parameter int unsigned c_flop_input   = 0,
    parameter int unsigned c_reset_state  = 0,
    parameter int unsigned c_single_bit   = 1,
    parameter int unsigned c_vector_width = 2,
    parameter int unsigned c_mtbf_stages  = 5
) (
    input  logic                      prmry_aclk,
    input  logic                      prmry_rst_n,
    input  logic                      scndry_aclk,
    input  logic                      scndry_rst_n,
    input  logic                      prmry_in,
    input  logic [c_vector_width-1:0] prmry_vect_in,
    output logic                      prmry_ack,
    output logic                      scndry_out,
    output logic [c_vector_width-1:0] scndry_vect_out
);

    localparam int unsigned STAGES   = clamp_mtbf(c_mtbf_stages);
    localparam int unsigned VW       = c_vector_width;
    localparam bit          IS_PULSE = (c_cdc_type == CDC_PULSE);
    localparam bit          IS_ACK   = (c_cdc_type == CDC_LEVEL_ACK);
    localparam bit          USE_RST  = (c_reset_state != 0);
    localparam bit          FLOP_IN  = (c_flop_input != 0);
    localparam bit          SINGLE   = (c_single_bit != 0);

    logic          prmry_arst_n;
    logic          scndry_arst_n;

    logic          in_q;
    logic [VW-1:0] vect_q;
    logic          toggle_q;
    logic          in_src;
    logic [VW-1:0] vect_src;
    logic          fwd_d;
    logic          fwd_q;
    logic          fwd_q_d;
    logic          pulse_q;
    logic [VW-1:0] vect_sync;
    logic          ack_q;
    logic          ack_q_d;
    logic          ack_pulse_q;

    // With c_reset_state=0 the reset pins are ignored and the flops only clear at power-up.
    assign prmry_arst_n  = USE_RST ? prmry_rst_n  : 1'b1;
    assign scndry_arst_n = USE_RST ? scndry_rst_n : 1'b1;

    // Source-domain input capture and toggle generator.
    always_ff @(posedge prmry_aclk or negedge prmry_arst_n) begin
        if (!prmry_arst_n) begin
            in_q     <= 1'b0;
            vect_q   <= '0;
            toggle_q <= 1'b0;
        end else begin
            in_q     <= prmry_in;
            vect_q   <= prmry_vect_in;
            toggle_q <= toggle_q ^ in_src;
        end
    end

    assign in_src   = FLOP_IN ? in_q   : prmry_in;
    assign vect_src = FLOP_IN ? vect_q : prmry_vect_in;

    // Pulse mode sends the toggle level across; level modes send the input itself.
    assign fwd_d = SINGLE ? (IS_PULSE ? toggle_q : in_src) : 1'b0;

    // Forward single-bit path.
    aurora_cdc_sync_chain #(
        .WIDTH  (1),
        .STAGES (STAGES)
    ) u_fwd_chain (
        .clk   (scndry_aclk),
        .rst_n (scndry_arst_n),
        .d     (fwd_d),
        .q     (fwd_q)
    );

    // Vector path: bitwise independent, no coherency across bits.
    aurora_cdc_sync_chain #(
        .WIDTH  (VW),
        .STAGES (STAGES)
    ) u_vect_chain (
        .clk   (scndry_aclk),
        .rst_n (scndry_arst_n),
        .d     (vect_src),
        .q     (vect_sync)
    );

    // Destination edge detect: any toggle transition becomes a single-cycle pulse.
    always_ff @(posedge scndry_aclk or negedge scndry_arst_n) begin
        if (!scndry_arst_n) begin
            fwd_q_d <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            fwd_q_d <= fwd_q;
            pulse_q <= fwd_q ^ fwd_q_d;
        end
    end

    assign scndry_out      = SINGLE ? (IS_PULSE ? pulse_q : fwd_q) : 1'b0;
    assign scndry_vect_out = SINGLE ? '0 : vect_sync;

    // Return path: the destination toggle (pulse) or destination level (level+ack)
    // is the same synchronised flop, so one chain serves both modes.
    aurora_cdc_sync_chain #(
        .WIDTH  (1),
        .STAGES (STAGES)
    ) u_ack_chain (
        .clk   (prmry_aclk),
        .rst_n (prmry_arst_n),
        .d     (fwd_q),
        .q     (ack_q)
    );

    // Source edge detect for the returned toggle.
    always_ff @(posedge prmry_aclk or negedge prmry_arst_n) begin
        if (!prmry_arst_n) begin
            ack_q_d     <= 1'b0;
            ack_pulse_q <= 1'b0;
        end else begin
            ack_q_d     <= ack_q;
            ack_pulse_q <= ack_q ^ ack_q_d;
        end
    end

    assign prmry_ack = IS_PULSE ? ack_pulse_q : (IS_ACK ? ack_q : 1'b0);

endmodule

// File: tb/tb_aurora_cdc_sync.sv
// Directed self-checking bench for aurora_cdc_sync.
// INIT_CLK (source, 100 MHz) period 100 units; USER_CLK (destination, 156.25 MHz) period 64 units.
// Rising edges of the two clocks are never closer than 2 units; outputs are sampled 1 unit after an edge.
module tb_aurora_cdc_sync;

    localparam int unsigned INIT_HALF = 50;
    localparam int unsigned USER_HALF = 32;
    localparam int unsigned SAMP      = 1;

    logic INIT_CLK;
    logic USER_CLK;
    logic p_rst_n;
    logic s_rst_n;
    logic r_s_rst_n;

    logic       lvl_in, vec_in, pls_in, ack_in, rst_in, gt_in;
    logic [1:0] lvl_vin, vec_vin, zero_v;

    logic       lvl_out, vec_out, pls_out, ack_out, rst_out, gt_rst_sync;
    logic       lvl_ack, vec_ack, pls_ack, ack_ack, rst_ack, gt_ack;
    logic [1:0] lvl_vout, vec_vout, pls_vout, ack_vout, rst_vout, gt_vout;

    int n_checks;
    int n_fail;
    int pls_hi;
    int pack_hi;
    logic seen;

    // Type 1, mtbf 5, no input flop, single bit.
    aurora_cdc_sync #(.c_cdc_type(1), .c_flop_input(0), .c_reset_state(1),
                      .c_single_bit(1), .c_vector_width(2), .c_mtbf_stages(5)) u_lvl (
        .prmry_aclk(INIT_CLK), .prmry_rst_n(p_rst_n), .scndry_aclk(USER_CLK),
        .scndry_rst_n(s_rst_n), .prmry_in(lvl_in), .prmry_vect_in(lvl_vin),
        .prmry_ack(lvl_ack), .scndry_out(lvl_out), .scndry_vect_out(lvl_vout));

    // Type 1, input flop, vector path W=2.
    aurora_cdc_sync #(.c_cdc_type(1), .c_flop_input(1), .c_reset_state(1),
                      .c_single_bit(0), .c_vector_width(2), .c_mtbf_stages(5)) u_vec (
        .prmry_aclk(INIT_CLK), .prmry_rst_n(p_rst_n), .scndry_aclk(USER_CLK),
        .scndry_rst_n(s_rst_n), .prmry_in(vec_in), .prmry_vect_in(vec_vin),
        .prmry_ack(vec_ack), .scndry_out(vec_out), .scndry_vect_out(vec_vout));

    // Type 0 pulse handshake.
    aurora_cdc_sync #(.c_cdc_type(0), .c_flop_input(0), .c_reset_state(1),
                      .c_single_bit(1), .c_vector_width(2), .c_mtbf_stages(5)) u_pls (
        .prmry_aclk(INIT_CLK), .prmry_rst_n(p_rst_n), .scndry_aclk(USER_CLK),
        .scndry_rst_n(s_rst_n), .prmry_in(pls_in), .prmry_vect_in(zero_v),
        .prmry_ack(pls_ack), .scndry_out(pls_out), .scndry_vect_out(pls_vout));

    // Type 2 level with acknowledge.
    aurora_cdc_sync #(.c_cdc_type(2), .c_flop_input(0), .c_reset_state(1),
                      .c_single_bit(1), .c_vector_width(2), .c_mtbf_stages(5)) u_ack (
        .prmry_aclk(INIT_CLK), .prmry_rst_n(p_rst_n), .scndry_aclk(USER_CLK),
        .scndry_rst_n(s_rst_n), .prmry_in(ack_in), .prmry_vect_in(zero_v),
        .prmry_ack(ack_ack), .scndry_out(ack_out), .scndry_vect_out(ack_vout));

    // Type 1 with its own destination reset for the reset tests.
    aurora_cdc_sync #(.c_cdc_type(1), .c_flop_input(0), .c_reset_state(1),
                      .c_single_bit(1), .c_vector_width(2), .c_mtbf_stages(5)) u_rst (
        .prmry_aclk(INIT_CLK), .prmry_rst_n(p_rst_n), .scndry_aclk(USER_CLK),
        .scndry_rst_n(r_s_rst_n), .prmry_in(rst_in), .prmry_vect_in(zero_v),
        .prmry_ack(rst_ack), .scndry_out(rst_out), .scndry_vect_out(rst_vout));

    // Reset-logic instance: resets held asserted but ignored (c_reset_state=0).
    aurora_cdc_sync #(.c_cdc_type(1), .c_flop_input(0), .c_reset_state(0),
                      .c_single_bit(1), .c_vector_width(2), .c_mtbf_stages(5)) u_gt (
        .prmry_aclk(INIT_CLK), .prmry_rst_n(1'b0), .scndry_aclk(USER_CLK),
        .scndry_rst_n(1'b0), .prmry_in(gt_in), .prmry_vect_in(zero_v),
        .prmry_ack(gt_ack), .scndry_out(gt_rst_sync), .scndry_vect_out(gt_vout));

    initial begin
        INIT_CLK = 1'b0;
        forever #(INIT_HALF) INIT_CLK = ~INIT_CLK;
    end

    initial begin
        USER_CLK = 1'b0;
        forever #(USER_HALF) USER_CLK = ~USER_CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_user(input int n);
        repeat (n) @(posedge USER_CLK);
        #(SAMP);
    endtask

    task automatic wait_init(input int n);
        repeat (n) @(posedge INIT_CLK);
        #(SAMP);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        p_rst_n   = 1'b0;
        s_rst_n   = 1'b0;
        r_s_rst_n = 1'b0;
        lvl_in = 1'b0; vec_in = 1'b0; pls_in = 1'b0;
        ack_in = 1'b0; rst_in = 1'b0; gt_in  = 1'b0;
        lvl_vin = 2'b11;
        vec_vin = 2'b00;
        zero_v  = 2'b00;

        // Reset state.
        wait_init(4);
        check_eq("rst_lvl_out",  32'(lvl_out),  32'd0);
        check_eq("rst_lvl_vout", 32'(lvl_vout), 32'd0);
        check_eq("rst_vec_vout", 32'(vec_vout), 32'd0);
        check_eq("rst_pls_out",  32'(pls_out),  32'd0);
        check_eq("rst_pls_ack",  32'(pls_ack),  32'd0);
        check_eq("rst_ack_out",  32'(ack_out),  32'd0);
        check_eq("rst_ack_ack",  32'(ack_ack),  32'd0);
        check_eq("rst_gt_sync",  32'(gt_rst_sync), 32'd0);
        @(negedge INIT_CLK);
        p_rst_n = 1'b1;
        s_rst_n = 1'b1;
        wait_init(10);

        // Level: 0->1 and 1->0 each take exactly 5 USER_CLK edges.
        @(negedge USER_CLK);
        lvl_in = 1'b1;
        wait_user(4);
        check_eq("lvl_rise_e4", 32'(lvl_out), 32'd0);
        wait_user(1);
        check_eq("lvl_rise_e5", 32'(lvl_out), 32'd1);
        check_eq("lvl_ack_zero", 32'(lvl_ack), 32'd0);
        @(negedge USER_CLK);
        lvl_in = 1'b0;
        wait_user(4);
        check_eq("lvl_fall_e4", 32'(lvl_out), 32'd1);
        wait_user(1);
        check_eq("lvl_fall_e5", 32'(lvl_out), 32'd0);
        check_eq("lvl_vout_unused", 32'(lvl_vout), 32'd0);

        // Vector with input flop: 1 INIT_CLK edge, then 5 USER_CLK edges.
        @(negedge INIT_CLK);
        vec_vin = 2'b10;
        wait_init(1);
        wait_user(4);
        check_eq("vec_e4", 32'(vec_vout), 32'd0);
        wait_user(1);
        check_eq("vec_e5", 32'(vec_vout), 32'h2);
        check_eq("vec_single_unused", 32'(vec_out), 32'd0);

        // Pulse: two separate handshakes, each one destination pulse and one ack.
        for (int p = 0; p < 2; p++) begin
            pls_hi  = 0;
            pack_hi = 0;
            fork
                begin
                    repeat (60) begin
                        @(posedge USER_CLK);
                        #(SAMP);
                        if (pls_out) pls_hi++;
                    end
                end
                begin
                    repeat (40) begin
                        @(posedge INIT_CLK);
                        #(SAMP);
                        if (pls_ack) pack_hi++;
                    end
                end
                begin
                    @(negedge INIT_CLK);
                    pls_in = 1'b1;
                    @(negedge INIT_CLK);
                    pls_in = 1'b0;
                end
            join
            check_eq(p == 0 ? "pls1_out_cycles" : "pls2_out_cycles", 32'(pls_hi), 32'd1);
            check_eq(p == 0 ? "pls1_ack_cycles" : "pls2_ack_cycles", 32'(pack_hi), 32'd1);
        end

        // Level with ack: ack rises exactly 5 INIT_CLK edges after scndry_out.
        @(negedge INIT_CLK);
        ack_in = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            wait_user(1);
            seen = ack_out;
        end
        check_eq("ack_fwd_seen", 32'(seen), 32'd1);
        wait_init(4);
        check_eq("ack_e4", 32'(ack_ack), 32'd0);
        wait_init(1);
        check_eq("ack_e5", 32'(ack_ack), 32'd1);

        // Destination reset holds the output low, release resynchronises in 5 edges.
        rst_in = 1'b1;
        wait_user(10);
        check_eq("rst_hold_out", 32'(rst_out), 32'd0);
        @(negedge USER_CLK);
        r_s_rst_n = 1'b1;
        wait_user(4);
        check_eq("rst_rel_e4", 32'(rst_out), 32'd0);
        wait_user(1);
        check_eq("rst_rel_e5", 32'(rst_out), 32'd1);
        @(negedge USER_CLK);
        r_s_rst_n = 1'b0;
        #(SAMP);
        check_eq("rst_mid_clear", 32'(rst_out), 32'd0);
        wait_user(3);
        check_eq("rst_mid_hold", 32'(rst_out), 32'd0);

        // Reset-logic case: resets ignored, GT reset appears on gt_rst_sync after 5 USER_CLK edges.
        check_eq("gt_idle", 32'(gt_rst_sync), 32'd0);
        @(negedge USER_CLK);
        gt_in = 1'b1;
        wait_user(4);
        check_eq("gt_e4", 32'(gt_rst_sync), 32'd0);
        wait_user(1);
        check_eq("gt_e5", 32'(gt_rst_sync), 32'd1);
        check_eq("gt_vout_unused", 32'(gt_vout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
